// File: rtl/cprs_pkg.sv
// Shared constants and helper functions for the cprs popcount pipeline.
// Tree sizing functions and the saturating accumulator add.
package cprs_pkg;

    function automatic int cprs_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Operand count after one 3:2 layer: each group of three becomes two.
    function automatic int cprs_next_k(input int k);
        return 2 * (k / 3) + (k % 3);
    endfunction

    function automatic int cprs_k_at(input int n, input int l);
        int k;
        k = n;
        for (int i = 0; i < l; i++) begin
            k = cprs_next_k(k);
        end
        return k;
    endfunction

    // Layers needed to reduce n operands down to the two fed to the adder.
    function automatic int cprs_layers(input int n);
        int k;
        int l;
        k = n;
        l = 0;
        while (k > 2) begin
            k = cprs_next_k(k);
            l++;
        end
        return l;
    endfunction

    // Returns {overflow, sum} with sum clamped to w bits of all-ones.
    function automatic logic [32:0] cprs_sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        if (sum > lim) begin
            return {1'b1, lim[31:0]};
        end
        return {1'b0, sum[31:0]};
    endfunction

endpackage

// File: rtl/cprs_3_2.sv
// Single-bit 3:2 compressor (full adder) cell.
// Sum keeps the bit weight, co carries to the next weight.
module cprs_3_2 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/cprs_layer.sv
// One combinational carry-save layer over K operands of W bits each.
// Groups of three become sum and shifted carry; leftovers pass through.
module cprs_layer
    import cprs_pkg::*;
#(
    parameter int K = 3,
    parameter int W = 3
) (
    input  logic [K*W-1:0]                ops_in,
    output logic [cprs_next_k(K)*W-1:0]   ops_out
);

    localparam int NC = K / 3;
    localparam int R  = K % 3;

    for (genvar c = 0; c < NC; c++) begin : g_cell
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic [W-1:0] s;
        logic [W-1:0] cy;

        assign a = ops_in[(3*c)*W +: W];
        assign b = ops_in[(3*c+1)*W +: W];
        assign d = ops_in[(3*c+2)*W +: W];

        for (genvar i = 0; i < W - 1; i++) begin : g_bit
            cprs_3_2 u_cell (
                .a  (a[i]),
                .b  (b[i]),
                .c  (d[i]),
                .s  (s[i]),
                .co (cy[i+1])
            );
        end

        // Top carry would leave the count width; the total never needs it.
        assign s[W-1] = a[W-1] ^ b[W-1] ^ d[W-1];
        assign cy[0]  = 1'b0;

        assign ops_out[(2*c)*W +: W]   = s;
        assign ops_out[(2*c+1)*W +: W] = cy;
    end

    for (genvar r = 0; r < R; r++) begin : g_pass
        assign ops_out[(2*NC+r)*W +: W] = ops_in[(3*NC+r)*W +: W];
    end

endmodule

// File: rtl/cprs_n_pipe.sv
// Two-stage pipelined popcount over a 3:2 compressor tree.
// Optional saturating accumulator built when CPRS_ACC_EN is defined.
module cprs_n_pipe
    import cprs_pkg::*;
#(
    parameter  int N_IN  = 16,
    parameter  int ACC_W = 16,
    localparam int CNT_W = cprs_cnt_w(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);

    localparam int LAYERS = cprs_layers(N_IN);
    localparam int HALF   = (LAYERS + 1) / 2;
    localparam int K_S1   = cprs_k_at(N_IN, HALF);

    logic                    s1_v;
    logic                    s2_v;
    logic                    s1_load;
    logic                    s2_load;
    logic                    s2_adv;
    logic [N_IN*CNT_W-1:0]   ops0;
    logic [K_S1*CNT_W-1:0]   s1_ops;
    logic [CNT_W-1:0]        cnt_next;

    // Each input bit becomes a CNT_W-wide operand of value 0 or 1.
    always_comb begin
        ops0 = '0;
        for (int i = 0; i < N_IN; i++) begin
            ops0[i*CNT_W] = in[i];
        end
    end

    for (genvar l = 0; l < LAYERS; l++) begin : g_lay
        localparam int KI = cprs_k_at(N_IN, l);
        localparam int KO = cprs_next_k(KI);

        logic [KI*CNT_W-1:0] li;
        logic [KO*CNT_W-1:0] lo;

        if (l == 0) begin : g_src_in
            assign li = ops0;
        end else if (l == HALF) begin : g_src_s1
            assign li = s1_ops;
        end else begin : g_src_prev
            assign li = g_lay[l-1].lo;
        end

        cprs_layer #(
            .K (KI),
            .W (CNT_W)
        ) u_layer (
            .ops_in  (li),
            .ops_out (lo)
        );
    end

    assign cnt_next = g_lay[LAYERS-1].lo[CNT_W-1:0]
                    + g_lay[LAYERS-1].lo[2*CNT_W-1:CNT_W];

    assign s2_adv    = s2_v & out_ready;
    assign s2_load   = s1_v & (~s2_v | s2_adv);
    assign in_ready  = rst_n & (~s1_v | s2_load);
    assign s1_load   = in_valid & in_ready;
    assign out_valid = s2_v & rst_n;

    // S1: partial sums after the first half of the tree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_ops <= '0;
        end else if (s1_load) begin
            s1_v   <= 1'b1;
            s1_ops <= g_lay[HALF-1].lo;
        end else if (s2_load) begin
            s1_v   <= 1'b0;
        end
    end

    // S2: final count, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v <= 1'b0;
            cnt  <= '0;
        end else if (s2_load) begin
            s2_v <= 1'b1;
            cnt  <= cnt_next;
        end else if (s2_adv) begin
            s2_v <= 1'b0;
        end
    end

`ifdef CPRS_ACC_EN
    logic [32:0] sat;
    logic        unused_sat;

    assign sat        = cprs_sat_add(32'(acc), 32'(cnt_next), ACC_W);
    assign unused_sat = ^sat;

    // Accumulator tracks S2 loads; a clear restarts it from the loading word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (s2_load) begin
            if (acc_clr) begin
                acc <= ACC_W'(cnt_next);
                ovf <= 1'b0;
            end else begin
                acc <= sat[ACC_W-1:0];
                ovf <= ovf | sat[32];
            end
        end else if (acc_clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end
    end
`else
    logic unused_clr;

    assign unused_clr = acc_clr;
    assign acc        = '0;
    assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_cprs_n_pipe.sv
// Directed and randomized checks of cprs_n_pipe at N_IN 4, 7, 16, 64.
// Accumulator expectations follow CPRS_ACC_EN when it is defined.
module tb_cprs_n_pipe;

`ifdef CPRS_ACC_EN
    localparam int AW2 = 5;
`else
    localparam int AW2 = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        acc_clr;
    logic [63:0] rin;
    logic [3:0]  rdy;
    logic [3:0]  ov;
    logic [3:0]  ovf_a;
    logic [6:0]  cnt_a [4];
    logic [15:0] acc_a [4];

    int          checks = 0;
    int          errors = 0;
    int          sent;
    logic [31:0] expq [$];
    int          amod [4];
    bit          omod [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int N  = (g == 0) ? 4 : (g == 1) ? 7 : (g == 2) ? 16 : 64;
        localparam int W  = $clog2(N + 1);
        localparam int AW = (g == 2) ? AW2 : 16;

        logic [W-1:0]  c;
        logic [AW-1:0] a;

        cprs_n_pipe #(
            .N_IN  (N),
            .ACC_W (AW)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (rdy[g]),
            .in        (rin[N-1:0]),
            .acc_clr   (acc_clr),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .cnt       (c),
            .acc       (a),
            .ovf       (ovf_a[g])
        );

        assign cnt_a[g] = 7'(c);
        assign acc_a[g] = 16'(a);
    end

    function automatic int nw(input int i);
        return (i == 0) ? 4 : (i == 1) ? 7 : (i == 2) ? 16 : 64;
    endfunction

    function automatic int alim(input int i);
        return (i == 2) ? ((1 << AW2) - 1) : 65535;
    endfunction

    function automatic logic [63:0] mask(input int n);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < n; b++) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] eacc(input int v);
`ifdef CPRS_ACC_EN
        return 64'(v);
`else
        return 64'(v * 0);
`endif
    endfunction

    function automatic logic [63:0] eovf(input int v);
`ifdef CPRS_ACC_EN
        return 64'(v);
`else
        return 64'(v * 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check();
        logic [31:0] e;
        int          c;
        chk("sw_q_nonempty", 64'(expq.size() != 0), 64'd1);
        if (expq.size() != 0) begin
            e = expq.pop_front();
            for (int i = 0; i < 4; i++) begin
                c = int'(e[i*8 +: 8]);
                chk("sw_ov_lockstep", 64'(ov[i]), 64'd1);
                chk("sw_cnt", 64'(cnt_a[i]), 64'(c));
                amod[i] = amod[i] + c;
                if (amod[i] > alim(i)) begin
                    amod[i] = alim(i);
                    omod[i] = 1'b1;
                end
                chk("sw_acc", 64'(acc_a[i]), eacc(amod[i]));
                chk("sw_ovf", 64'(ovf_a[i]), eovf(int'(omod[i])));
            end
        end
    endtask

    logic [15:0] words [3];
    int          exps  [3];
    int          wi;
    int          got;
    logic [31:0] pk;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        acc_clr   = 1'b0;
        rin       = '0;

        // reset state
        tick();
        tick();
        chk("rst_out_valid", 64'(ov[2]), 64'd0);
        chk("rst_cnt", 64'(cnt_a[2]), 64'd0);
        chk("rst_acc", 64'(acc_a[2]), 64'd0);
        chk("rst_ovf", 64'(ovf_a[2]), 64'd0);
        chk("rst_in_ready", 64'(rdy[2]), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 64'(rdy[2]), 64'd1);

        // back-to-back stream, latency 2
        in_valid = 1'b1;
        rin = 64'h0000;
        tick();
        rin = 64'hFFFF;
        chk("st_lat_no_ov", 64'(ov[2]), 64'd0);
        tick();
        rin = 64'h00F1;
        chk("st_ov0", 64'(ov[2]), 64'd1);
        chk("st_cnt0", 64'(cnt_a[2]), 64'd0);
        chk("st_acc0", 64'(acc_a[2]), eacc(0));
        tick();
        in_valid = 1'b0;
        chk("st_ov1", 64'(ov[2]), 64'd1);
        chk("st_cnt1", 64'(cnt_a[2]), 64'd16);
        chk("st_acc1", 64'(acc_a[2]), eacc(16));
        tick();
        chk("st_ov2", 64'(ov[2]), 64'd1);
        chk("st_cnt2", 64'(cnt_a[2]), 64'd5);
        chk("st_acc2", 64'(acc_a[2]), eacc(21));
        tick();
        chk("st_drained", 64'(ov[2]), 64'd0);

        // backpressure: 5 stalled cycles, 3 words offered
        words[0] = 16'h0003; exps[0] = 2;
        words[1] = 16'h0F00; exps[1] = 4;
        words[2] = 16'hFFFE; exps[2] = 15;
        wi = 0;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            tick();
            out_ready = (c >= 5);
            in_valid  = (wi < 3);
            rin       = (wi < 3) ? 64'(words[wi]) : 64'h0;
            #1;
            if (c == 2) chk("bp_in_ready_low", 64'(rdy[2]), 64'd0);
            if (c >= 2 && c < 5) begin
                chk("bp_hold_ov", 64'(ov[2]), 64'd1);
                chk("bp_hold_cnt", 64'(cnt_a[2]), 64'd2);
            end
            if (in_valid && rdy[2]) wi++;
            if (ov[2] && out_ready) begin
                chk("bp_order", 64'(cnt_a[2]), 64'(exps[got]));
                got++;
            end
        end
        chk("bp_all_out", 64'(got), 64'd3);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // saturation and clear
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        tick();
        chk("clr_acc", 64'(acc_a[2]), 64'd0);
        chk("clr_ovf", 64'(ovf_a[2]), 64'd0);
        in_valid = 1'b1;
        rin = 64'hFFFF;
        tick();
        tick();
        in_valid = 1'b0;
        chk("sat_cnt_a", 64'(cnt_a[2]), 64'd16);
        chk("sat_acc_a", 64'(acc_a[2]), eacc(16));
        chk("sat_ovf_a", 64'(ovf_a[2]), 64'd0);
        tick();
        chk("sat_cnt_b", 64'(cnt_a[2]), 64'd16);
        chk("sat_acc_b", 64'(acc_a[2]), eacc((AW2 == 5) ? 31 : 32));
        chk("sat_ovf_b", 64'(ovf_a[2]), eovf((AW2 == 5) ? 1 : 0));
        tick();
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        tick();
        chk("sat_clr_acc", 64'(acc_a[2]), 64'd0);
        chk("sat_clr_ovf", 64'(ovf_a[2]), 64'd0);

        // clear coincident with an S2 load
        in_valid = 1'b1;
        rin = 64'hFFFF;
        tick();
        rin = 64'h0007;
        tick();
        in_valid = 1'b0;
        acc_clr = 1'b1;
        chk("cc_pre_acc", 64'(acc_a[2]), eacc(16));
        tick();
        acc_clr = 1'b0;
        chk("cc_cnt", 64'(cnt_a[2]), 64'd3);
        chk("cc_acc", 64'(acc_a[2]), eacc(3));
        chk("cc_ovf", 64'(ovf_a[2]), 64'd0);
        tick();

        // reset with two words in flight
        in_valid = 1'b1;
        rin = 64'h1234;
        tick();
        rin = 64'h00FF;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_no_ov_a", 64'(ov[2]), 64'd0);
        chk("mr_ready_low", 64'(rdy[2]), 64'd0);
        tick();
        chk("mr_no_ov_b", 64'(ov[2]), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("mr_no_ov_c", 64'(ov[2]), 64'd0);
        tick();
        in_valid = 1'b1;
        rin = 64'h8001;
        #1;
        chk("mr_no_ov_d", 64'(ov[2]), 64'd0);
        chk("mr_ready", 64'(rdy[2]), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("mr_lat1", 64'(ov[2]), 64'd0);
        tick();
        chk("mr_lat2_ov", 64'(ov[2]), 64'd1);
        chk("mr_cnt", 64'(cnt_a[2]), 64'd2);
        chk("mr_acc", 64'(acc_a[2]), eacc(2));
        tick();

        // random sweep across all widths
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            amod[i] = 0;
            omod[i] = 1'b0;
        end
        sent = 0;
        for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
            tick();
            in_valid  = ($urandom_range(0, 3) != 0);
            rin       = {$urandom(), $urandom()};
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            for (int i = 0; i < 4; i++) begin
                pk[i*8 +: 8] = 8'($countones(rin & mask(nw(i))));
            end
            if (ov[2] && out_ready) pop_check();
            if (in_valid && rdy[2]) begin
                expq.push_back(pk);
                sent++;
            end
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && expq.size() != 0; k++) begin
            #1;
            if (ov[2]) pop_check();
            tick();
        end
        chk("sw_sent", 64'(sent), 64'd10000);
        chk("sw_drain_empty", 64'(expq.size()), 64'd0);
        chk("sw_final_idle", 64'(ov[2]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cprs_n_pipe.md
CPRS_N_PIPE -- requirements
Module: cprs_n_pipe

Interface
REQ-001 Parameter N_IN, default 16: number of input bits counted per transaction; legal range 4..64.
REQ-002 Parameter ACC_W, default 16: accumulator width; legal range CNT_W..32.
REQ-003 Derived constant CNT_W = clog2(N_IN+1), giving 5 bits at the default N_IN.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_ready  output  1  block accepts the input word this cycle.
REQ-008 in  input  N_IN  bits to be counted.
REQ-009 acc_clr  input  1  clears the accumulator (accumulator build only).
REQ-010 out_valid  output  1  cnt and acc are valid.
REQ-011 out_ready  input  1  downstream accepts the output.
REQ-012 cnt  output  CNT_W  number of ones in the accepted word.
REQ-013 acc  output  ACC_W  running sum of cnt values.
REQ-014 ovf  output  1  sticky flag: the accumulator has saturated.

Function
REQ-015 cnt SHALL equal popcount(in) of the corresponding accepted word, exact for every value 0..N_IN.
REQ-016 Counting SHALL use a tree of 3:2 compressor cells, with N_IN/3 cells per layer and any remainder bits passed through; an adder SHALL be used only in the final layer.
REQ-017 Pipeline: S1 registers the compressor-tree partial sums after ceil(layers/2) layers; S2 registers the final cnt. Latency SHALL be exactly 2 cycles from input handshake to out_valid when there is no backpressure.
REQ-018 Input handshake occurs when in_valid && in_ready; output handshake occurs when out_valid && out_ready.
REQ-019 Each stage SHALL load when it is empty or when the stage after it is advancing in the same cycle: S2 advances on the output handshake; S1 advances when S2 is empty or advancing.
REQ-020 in_ready SHALL be high when S1 is empty or S1 advances in this cycle; full throughput is 1 word/cycle.
REQ-021 While out_valid && !out_ready, cnt, acc and out_valid SHALL hold stable; no word is dropped or duplicated.
REQ-022 Accumulator: on each S2 load, acc_next = sat(acc + cnt_new); acc is presented with its matching cnt.
REQ-023 Saturation: a sum above 2^ACC_W-1 SHALL clamp acc to all-ones and set ovf; ovf stays set until acc_clr or reset.
REQ-024 acc_clr, when sampled high, SHALL clear acc and ovf. If a word loads S2 in the same cycle, acc = cnt of that word and ovf = 0.
REQ-025 in = all-zero SHALL still produce an output transaction with cnt = 0.

Reset
REQ-026 With rst_n low at a clock edge: S1 and S2 become empty, out_valid=0, cnt=0, acc=0, ovf=0.
REQ-027 While rst_n is low, in_ready=0; in-flight words are discarded when reset is asserted mid-operation.
REQ-028 in_ready SHALL go high on the first edge after rst_n is deasserted.

Configuration
REQ-029 Macro CPRS_ACC_EN, when defined, SHALL build the accumulator, acc_clr, acc and ovf per REQ-022..024.
REQ-030 Without CPRS_ACC_EN, the ports SHALL remain, acc and ovf SHALL be driven 0, acc_clr SHALL be ignored, and no accumulator flops SHALL exist.

Structure
REQ-031 Package cprs_pkg SHALL hold the CNT_W function clog2(N+1), the layer-count function for N inputs, and the saturating-add function.
REQ-032 Sub-module cprs_layer SHALL implement one parametrised combinational compression layer, built by instancing the existing cprs_3_2 cell.
REQ-033 cprs_n_pipe SHALL instance cprs_layer per layer through generate loops and own all pipeline and accumulator registers.

Verification
REQ-034 Stream, N_IN=16, out_ready=1: words 0x0000, 0xFFFF, 0x00F1 on consecutive cycles -> cnt 0, 16, 5 on cycles 2, 3, 4 with no bubbles.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles with 3 words offered -> in_ready falls after S1 and S2 fill; outputs are held stable; after release, order is preserved with none lost.
REQ-036 Saturation, CPRS_ACC_EN, ACC_W=5: send 0xFFFF twice -> acc 16, then 31 with ovf=1; acc_clr pulse -> acc=0, ovf=0.
REQ-037 acc_clr coincident with S2 load of word 0x0007 -> acc=3, ovf=0.
REQ-038 Assert reset on the cycle after 2 words are accepted -> no out_valid appears; after release, a fresh word 0x8001 gives cnt=2 with latency 2.
REQ-039 Random sweep for N_IN in {4,7,16,64}, 10k words, random valid/ready -> cnt matches a popcount model; in the non-ACC build, acc=0 and ovf=0 throughout.
